decode_ctrl_stage: RTL
======================

# decode_ctrl_stage

Second-generation decode-stage control block for the pipelined RV32 core. It fully decodes RV32I plus, optionally, RV32M, and registers the control word into the Decode/Execute pipeline boundary. It also sequences multi-cycle MUL/DIV operations by holding Execute and requesting a front-end stall. It sits between the Decode-stage instruction register and the Execute stage, alongside the hazard unit.

## Interface
Parameters:
- `ENABLE_M`, default 1: 1 decodes RV32M (opcode 0110011, funct7 0000001); 0 treats those encodings as illegal.
- `MULDIV_LAT`, default 4, legal range 1..32: total Execute cycles occupied by a MUL/DIV.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `InstrD`, input, 32: Decode-stage instruction.
- `ValidD`, input, 1: `InstrD` holds a real instruction.
- `FlushE`, input, 1: from the hazard unit; inserts a bubble into Execute.
- `ImmSrcD`, output, 3: combinational immediate select. Encodings: 000 I, 001 S, 010 B, 011 J, 100 U.
- `RegWriteE`, `MemWriteE`, `JumpE`, `BranchE`, `AluSrcE`, `AluSrcAE`, output, 1 each: registered controls. `AluSrcE` 1 selects the immediate; `AluSrcAE` 1 selects PC as operand A.
- `ResultSrcE`, output, 2: registered result select. Encodings: 00 ALU, 01 memory, 10 PC+4.
- `ALUControlE`, output, 5: registered ALU operation code.
- `Funct3E`, output, 3: registered funct3, used for load/store width and branch condition.
- `ValidE`, `IllegalE`, output, 1 each: registered valid flag and illegal-instruction flag.
- `StallReq`, output, 1: combinational request to freeze F/D.
- `MulDivDoneE`, output, 1: combinational pulse, high in the final cycle of a MUL/DIV.

## Operation
- ALU control encodings:
  - Base ops: 00000 add, 00001 sub, 00010 xor, 00011 or, 00100 and, 00101 sll, 00110 srl, 00111 sra, 01000 slt, 01001 sltu, 01010 pass-B.
  - M-extension ops: 10000 mul, 10001 mulh, 10010 mulhsu, 10011 mulhu, 10100 div, 10101 divu, 10110 rem, 10111 remu.
- R-type: RegWrite=1 and AluSrc=0. funct7 must be 0000000, or 0100000 for sub/sra only.
- OP-IMM: uses the I immediate with AluSrc=1.
  - slli/srli require funct7=0000000; srai requires funct7=0100000.
  - Any other funct7 on a shift is illegal.
- Loads: funct3 must be 000/001/010/100/101. ALU op is add; ResultSrc=01.
- Stores: funct3 must be 000/001/010. MemWrite=1, RegWrite=0, ImmSrc S.
- Branches: funct3 must not be 010/011. Branch=1, ALU op sub, ImmSrc B.
- jal: Jump=1, RegWrite=1, ResultSrc=10, ImmSrc J.
- jalr: funct3 must be 000. Same as jal, but ImmSrc I and AluSrc=1 (target = rs1+imm).
- lui: ALU op pass-B, ImmSrc U.
- auipc: ALU op add, AluSrcA=1, ImmSrc U.
- ecall/ebreak: treated as legal no-ops, with all enables 0.
- Any other encoding, including InstrD[1:0]≠11, is illegal.
  - For an illegal instruction, all write/jump/branch enables are 0.
  - IllegalE is 1 if ValidD was 1.
- When ValidD=0, the loaded control word is a bubble.
- A bubble is: all enables 0, ValidE=0, IllegalE=0, ALUControlE=00000, ResultSrcE=00.
- The MUL/DIV sequencer is a down-counter `cnt` of width ceil(log2(MULDIV_LAT))+1.
  - The Execute register loads when cnt==0 and FlushE==0.
  - Loading a valid MUL/DIV sets cnt=MULDIV_LAT-1; any other load leaves cnt=0.
  - While cnt≠0, the E register holds and cnt decrements by 1 each cycle.
- StallReq = (cnt≠0).
- MulDivDoneE = ValidE & ALUControlE[4] & (cnt==0).

## Timing
- Reset (asynchronous, rst_n=0): E register holds a bubble and cnt=0. Therefore StallReq=0 and MulDivDoneE=0.
- Decode-to-Execute latency: one cycle. ImmSrcD has zero latency (combinational).
- FlushE has priority over both hold and load.
  - A flush during a MUL/DIV aborts it: bubble loaded, cnt=0, StallReq drops next cycle.
- With MULDIV_LAT=1 a MUL/DIV behaves like any single-cycle op: StallReq is never asserted, and MulDivDoneE is high during its only E cycle.
- MUL/DIV occupies E for exactly MULDIV_LAT cycles.
  - StallReq is high for the first MULDIV_LAT-1 of those cycles.
  - The next D instruction loads on the edge after MulDivDoneE.
- Back-to-back MUL/DIV: the second one loads on the edge ending the first one's done cycle, and its cnt reloads immediately.
- If rst_n is deasserted mid-sequence, the sequence is abandoned with no residual stall.

## Test plan
- Reset with ENABLE_M=1, MULDIV_LAT=4 → bubble in E, StallReq=0. Apply ValidD with add x3,x1,x2 (0x002081B3) → next cycle RegWriteE=1, ALUControlE=00000, ValidE=1.
- mul x5,x6,x7 (0x027302B3), followed by add → StallReq high for 3 cycles. MulDivDoneE is high in cycle 4. The add appears in E in cycle 5.
- Same mul with FlushE pulsed in its 2nd E cycle → bubble next cycle, StallReq=0, MulDivDoneE never asserted.
- Illegal encodings 0xFFFFFFFF, and slli with funct7=0100000 → IllegalE=1, RegWriteE=0, MemWriteE=0. The same encodings with ValidD=0 → IllegalE=0.
- ENABLE_M=0 with mul → IllegalE=1 and StallReq never asserted.
- Full RV32I sweep covering sw, beq, jal, jalr, lui, auipc, lw:
  - sw: ImmSrcD=001, MemWriteE=1.
  - beq: ALUControlE=00001, BranchE=1.
  - jal: ResultSrcE=10, JumpE=1.
  - lui: ALUControlE=01010.
  - auipc: AluSrcAE=1.
  - lw: ResultSrcE=01, Funct3E=010.

Source files
------------

// File: rtl/decode_ctrl_stage.sv
// RV32I(+M) decode control with the Decode/Execute control register and a
// MUL/DIV hold sequencer that freezes Execute and stalls the front end.
module decode_ctrl_stage #(
    parameter int ENABLE_M   = 1,
    parameter int MULDIV_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] InstrD,
    input  logic        ValidD,
    input  logic        FlushE,
    output logic [2:0]  ImmSrcD,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        JumpE,
    output logic        BranchE,
    output logic        AluSrcE,
    output logic        AluSrcAE,
    output logic [1:0]  ResultSrcE,
    output logic [4:0]  ALUControlE,
    output logic [2:0]  Funct3E,
    output logic        ValidE,
    output logic        IllegalE,
    output logic        StallReq,
    output logic        MulDivDoneE
);

    localparam int CNT_W = $clog2(MULDIV_LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 1);

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_XOR  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_AND  = 5'b00100;
    localparam logic [4:0] ALU_SLL  = 5'b00101;
    localparam logic [4:0] ALU_SRL  = 5'b00110;
    localparam logic [4:0] ALU_SRA  = 5'b00111;
    localparam logic [4:0] ALU_SLT  = 5'b01000;
    localparam logic [4:0] ALU_SLTU = 5'b01001;
    localparam logic [4:0] ALU_PASSB = 5'b01010;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src;
        logic       alu_src_a;
        logic [1:0] result_src;
        logic [4:0] alu_ctrl;
        logic [2:0] funct3;
        logic       valid;
        logic       illegal;
    } ctrl_t;

    // Shared funct3 -> ALU op map for register and immediate arithmetic.
    function automatic logic [4:0] base_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  base_alu = ALU_ADD;
            3'b001:  base_alu = ALU_SLL;
            3'b010:  base_alu = ALU_SLT;
            3'b011:  base_alu = ALU_SLTU;
            3'b100:  base_alu = ALU_XOR;
            3'b101:  base_alu = ALU_SRL;
            3'b110:  base_alu = ALU_OR;
            default: base_alu = ALU_AND;
        endcase
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    ctrl_t      dec;
    logic [2:0] imm_src;
    logic       legal;
    ctrl_t      load_word;
    ctrl_t      ctrl_d, ctrl_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign funct7 = InstrD[31:25];

    always_comb begin
        dec        = '0;
        dec.funct3 = funct3;
        imm_src    = IMM_I;
        legal      = 1'b0;
        case (opcode)
            7'b0110011: begin
                dec.reg_write = 1'b1;
                case (funct7)
                    7'b0000000: begin
                        legal        = 1'b1;
                        dec.alu_ctrl = base_alu(funct3);
                    end
                    7'b0100000: begin
                        legal        = (funct3 == 3'b000) || (funct3 == 3'b101);
                        dec.alu_ctrl = (funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
                    end
                    7'b0000001: begin
                        legal        = (ENABLE_M != 0);
                        dec.alu_ctrl = {2'b10, funct3};
                    end
                    default: legal = 1'b0;
                endcase
            end
            7'b0010011: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = base_alu(funct3);
                if (funct3 == 3'b001) begin
                    legal = (funct7 == 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    legal        = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    dec.alu_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
                end else begin
                    legal = 1'b1;
                end
            end
            7'b0000011: begin
                legal          = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = RES_MEM;
            end
            7'b0100011: begin
                legal         = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                imm_src       = IMM_S;
            end
            7'b1100011: begin
                legal        = (funct3 != 3'b010) && (funct3 != 3'b011);
                dec.branch   = 1'b1;
                dec.alu_ctrl = ALU_SUB;
                imm_src      = IMM_B;
            end
            7'b1101111: begin
                legal          = 1'b1;
                dec.jump       = 1'b1;
                dec.reg_write  = 1'b1;
                dec.result_src = RES_PC4;
                imm_src        = IMM_J;
            end
            7'b1100111: begin
                legal          = (funct3 == 3'b000);
                dec.jump       = 1'b1;
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = RES_PC4;
            end
            7'b0110111: begin
                legal         = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = ALU_PASSB;
                imm_src       = IMM_U;
            end
            7'b0010111: begin
                legal         = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_src_a = 1'b1;
                imm_src       = IMM_U;
            end
            7'b1110011: begin
                // Only ecall/ebreak are accepted; CSR and other SYSTEM forms trap.
                legal = (InstrD == 32'h0000_0073) || (InstrD == 32'h0010_0073);
                dec   = '0;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec     = '0;
            imm_src = IMM_I;
        end
    end

    assign ImmSrcD = imm_src;

    always_comb begin
        load_word = '0;
        if (ValidD) begin
            load_word         = dec;
            load_word.valid   = 1'b1;
            load_word.illegal = !legal;
        end
    end

    // Flush beats hold, hold beats load; a loaded MUL/DIV arms the counter.
    always_comb begin
        ctrl_d = ctrl_q;
        cnt_d  = cnt_q;
        if (FlushE) begin
            ctrl_d = '0;
            cnt_d  = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            ctrl_d = load_word;
            cnt_d  = (load_word.valid && load_word.alu_ctrl[4]) ? CNT_LOAD : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
            cnt_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            cnt_q  <= cnt_d;
        end
    end

    assign RegWriteE   = ctrl_q.reg_write;
    assign MemWriteE   = ctrl_q.mem_write;
    assign JumpE       = ctrl_q.jump;
    assign BranchE     = ctrl_q.branch;
    assign AluSrcE     = ctrl_q.alu_src;
    assign AluSrcAE    = ctrl_q.alu_src_a;
    assign ResultSrcE  = ctrl_q.result_src;
    assign ALUControlE = ctrl_q.alu_ctrl;
    assign Funct3E     = ctrl_q.funct3;
    assign ValidE      = ctrl_q.valid;
    assign IllegalE    = ctrl_q.illegal;
    assign StallReq    = (cnt_q != '0);
    assign MulDivDoneE = ctrl_q.valid & ctrl_q.alu_ctrl[4] & (cnt_q == '0);

endmodule
